stack_bus_upstream_arb: RTL and testbench

//   Upstream concentrator between the PE array and the stack bus. Collects result packets from NUM_PE
//   PE upstream ports and arbitrates them round-robin, never interleaving packets. Buffers accepted

---
 rtl/stack_bus_upstream_arb_pkg.sv | 42 ++++
 rtl/generic_fifo_sync.sv | 62 ++++++
 rtl/stack_bus_upstream_arb.sv | 150 +++++++++++++++
 tb/tb_stack_bus_upstream_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_bus_upstream_arb_pkg.sv
// Shared definitions for the stack bus upstream concentrator.
// Optional feature macro: STACK_BUS_UP_PARITY_EN (adds even parity per buffered beat).
package stack_bus_upstream_arb_pkg;

    localparam int unsigned NUM_PE     = 4;
    localparam int unsigned PE_ID_W    = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned CNTL_W     = 2;

    typedef enum logic [1:0] {
        CNTL_SOP     = 2'b00,
        CNTL_MOP     = 2'b01,
        CNTL_EOP     = 2'b10,
        CNTL_SOP_EOP = 2'b11
    } cntl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PE_ID_W-1:0] pe_id;
        logic [CNTL_W-1:0]  cntl;
        logic [DATA_W-1:0]  data;
    } up_beat_t;

    localparam int unsigned BEAT_W = $bits(up_beat_t);

`ifdef STACK_BUS_UP_PARITY_EN
    localparam int unsigned FIFO_W = BEAT_W + 1;

    // Even parity: stored bit makes the total number of ones even.
    function automatic logic beat_parity(input up_beat_t beat);
        return ^beat;
    endfunction
`else
    localparam int unsigned FIFO_W = BEAT_W;
`endif

endpackage

// File: rtl/generic_fifo_sync.sv
// Synchronous FIFO with registered storage, registered full/empty flags and
// simultaneous push/pop. Pushes while full and pops while empty are ignored.
module generic_fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Pointers, occupancy, flags and storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

endmodule

// File: rtl/stack_bus_upstream_arb.sv
// Upstream concentrator: round-robin packet arbitration over NUM_PE PE ports,
// buffered into a FIFO and presented to the stack bus manager tagged with PE id.
// Optional feature macro: STACK_BUS_UP_PARITY_EN (adds mgr_up_parity output).
module stack_bus_upstream_arb
    import stack_bus_upstream_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_poweron,
    input  logic [NUM_PE-1:0]         pe_up_valid,
    input  logic [CNTL_W*NUM_PE-1:0]  pe_up_cntl,
    input  logic [DATA_W*NUM_PE-1:0]  pe_up_data,
    output logic [NUM_PE-1:0]         pe_up_ready,
    output logic                      mgr_up_valid,
    output logic [CNTL_W-1:0]         mgr_up_cntl,
    output logic [DATA_W-1:0]         mgr_up_data,
    output logic [PE_ID_W-1:0]        mgr_up_pe_id,
    input  logic                      mgr_up_ready,
    output logic                      proto_err
`ifdef STACK_BUS_UP_PARITY_EN
    ,
    output logic                      mgr_up_parity
`endif
);

    arb_state_e         state;
    logic [PE_ID_W-1:0] rr_ptr;
    logic [PE_ID_W-1:0] grant;
    logic [PE_ID_W-1:0] pick;
    logic [PE_ID_W-1:0] idx;
    logic               found;
    logic               first_beat;
    logic               accept;
    logic               beat_err;
    logic [CNTL_W-1:0]  sel_cntl;
    logic [DATA_W-1:0]  sel_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    up_beat_t           push_beat;
    up_beat_t           head_beat;
    logic [FIFO_W-1:0]  fifo_wdata;
    logic [FIFO_W-1:0]  fifo_head;

    assign sel_cntl = pe_up_cntl[grant*CNTL_W +: CNTL_W];
    assign sel_data = pe_up_data[grant*DATA_W +: DATA_W];
    assign accept   = (state == ST_XFER) && pe_up_valid[grant] && !fifo_full;

    // First requesting PE at or after rr_ptr, wrapping modulo NUM_PE.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            idx = rr_ptr + PE_ID_W'(i);
            if (!found && pe_up_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Only the granted PE sees ready, and only while the FIFO has room.
    always_comb begin
        pe_up_ready = '0;
        if (state == ST_XFER && !fifo_full) begin
            pe_up_ready[grant] = 1'b1;
        end
    end

    // Packet framing check on the accepted beat.
    always_comb begin
        if (first_beat) begin
            beat_err = (sel_cntl == CNTL_MOP) || (sel_cntl == CNTL_EOP);
        end else begin
            beat_err = (sel_cntl == CNTL_SOP) || (sel_cntl == CNTL_SOP_EOP);
        end
    end

    // Arbiter FSM: grant in IDLE, hold the grant until the packet ends.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            first_beat <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pe_up_valid) begin
                        grant      <= pick;
                        first_beat <= 1'b1;
                        state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (beat_err) begin
                            proto_err <= 1'b1;
                        end
                        if (sel_cntl[1]) begin
                            state  <= ST_IDLE;
                            rr_ptr <= grant + PE_ID_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO write word: tagged beat, plus parity when enabled.
    always_comb begin
        push_beat.pe_id = grant;
        push_beat.cntl  = sel_cntl;
        push_beat.data  = sel_data;
`ifdef STACK_BUS_UP_PARITY_EN
        fifo_wdata = {beat_parity(push_beat), push_beat};
`else
        fifo_wdata = push_beat;
`endif
    end

    assign fifo_pop = mgr_up_valid && mgr_up_ready;

    generic_fifo_sync #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset_poweron),
        .push      (accept),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_beat    = up_beat_t'(fifo_head[BEAT_W-1:0]);
    assign mgr_up_valid = !fifo_empty;
    assign mgr_up_cntl  = head_beat.cntl;
    assign mgr_up_data  = head_beat.data;
    assign mgr_up_pe_id = head_beat.pe_id;
`ifdef STACK_BUS_UP_PARITY_EN
    assign mgr_up_parity = fifo_head[BEAT_W];
`endif

endmodule

// File: tb/tb_stack_bus_upstream_arb.sv
// Bench for stack_bus_upstream_arb: latency vector table, scoreboarded packet
// sequences (ordering, back-pressure, protocol errors, mid-packet reset) and
// the optional parity output when STACK_BUS_UP_PARITY_EN is defined.
module tb_stack_bus_upstream_arb;
    import stack_bus_upstream_arb_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset_poweron;
    logic [NUM_PE-1:0]        pe_up_valid;
    logic [2*NUM_PE-1:0]      pe_up_cntl;
    logic [DATA_W*NUM_PE-1:0] pe_up_data;
    logic [NUM_PE-1:0]        pe_up_ready;
    logic                     mgr_up_valid;
    logic [1:0]               mgr_up_cntl;
    logic [DATA_W-1:0]        mgr_up_data;
    logic [PE_ID_W-1:0]       mgr_up_pe_id;
    logic                     mgr_up_ready;
    logic                     proto_err;
`ifdef STACK_BUS_UP_PARITY_EN
    logic                     mgr_up_parity;
`endif

    always #5 clk = ~clk;

    stack_bus_upstream_arb dut (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .pe_up_valid   (pe_up_valid),
        .pe_up_cntl    (pe_up_cntl),
        .pe_up_data    (pe_up_data),
        .pe_up_ready   (pe_up_ready),
        .mgr_up_valid  (mgr_up_valid),
        .mgr_up_cntl   (mgr_up_cntl),
        .mgr_up_data   (mgr_up_data),
        .mgr_up_pe_id  (mgr_up_pe_id),
        .mgr_up_ready  (mgr_up_ready),
        .proto_err     (proto_err)
`ifdef STACK_BUS_UP_PARITY_EN
        ,
        .mgr_up_parity (mgr_up_parity)
`endif
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [1:0]  cntl;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          pe;
        logic [1:0]  cntl;
        logic [31:0] data;
        logic        exp_err;
    } vec_t;

    sb_t pe_q [NUM_PE][$];
    sb_t exp_q [$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic sb_t mk(input int id, input logic [1:0] cntl, input logic [31:0] data);
        sb_t b;
        b.id   = 2'(id);
        b.cntl = cntl;
        b.data = data;
        return b;
    endfunction

    function automatic bit all_pe_empty();
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Present the head of each PE's queue on its port.
    task automatic drive_pe();
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_q[i].size() > 0) begin
                pe_up_valid[i]          = 1'b1;
                pe_up_cntl[i*2 +: 2]    = pe_q[i][0].cntl;
                pe_up_data[i*32 +: 32]  = pe_q[i][0].data;
            end else begin
                pe_up_valid[i]          = 1'b0;
                pe_up_cntl[i*2 +: 2]    = 2'b00;
                pe_up_data[i*32 +: 32]  = '0;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, check pops, advance PE queues.
    task automatic tick();
        logic [NUM_PE-1:0] acc;
        sb_t got;
        sb_t want;
        @(negedge clk);
        acc = pe_up_valid & pe_up_ready;
        if (mgr_up_valid && mgr_up_ready) begin
            got = mk(int'(mgr_up_pe_id), mgr_up_cntl, mgr_up_data);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra_beat: got %h expected no beat", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL sb_beat: got %h expected %h", got, want);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_PE; i++) begin
            if (acc[i]) void'(pe_q[i].pop_front());
        end
        drive_pe();
    endtask

    task automatic run_drain(input int max_cyc, input string nm);
        int c;
        c = 0;
        while (c < max_cyc && !(all_pe_empty() && exp_q.size() == 0)) begin
            tick();
            c++;
        end
        n_vec++;
        if (!(all_pe_empty() && exp_q.size() == 0)) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d beats outstanding expected 0", nm, exp_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NUM_PE; i++) pe_q[i].delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_poweron = 1'b1;
        clear_queues();
        drive_pe();
        mgr_up_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_poweron = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [4];

    initial begin
        reset_poweron = 1'b1;
        mgr_up_ready  = 1'b1;
        pe_up_valid   = '0;
        pe_up_cntl    = '0;
        pe_up_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pe_up_ready", 64'(pe_up_ready), 64'(0));
        chk("rst_mgr_up_valid", 64'(mgr_up_valid), 64'(0));
        chk("rst_mgr_up_data", 64'(mgr_up_data), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        @(negedge clk);
        reset_poweron = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat latency vectors: valid at N, ready at N+1, output at N+2.
        vecs[0] = '{pe: 0, cntl: 2'b11, data: 32'h0000_00A5, exp_err: 1'b0};
        vecs[1] = '{pe: 3, cntl: 2'b11, data: 32'hDEAD_BEEF, exp_err: 1'b0};
        vecs[2] = '{pe: 1, cntl: 2'b11, data: 32'h0000_0000, exp_err: 1'b0};
        vecs[3] = '{pe: 2, cntl: 2'b11, data: 32'hFFFF_FFFF, exp_err: 1'b0};
        foreach (vecs[k]) begin
            pe_up_valid                    = '0;
            pe_up_valid[vecs[k].pe]        = 1'b1;
            pe_up_cntl[vecs[k].pe*2 +: 2]  = vecs[k].cntl;
            pe_up_data[vecs[k].pe*32 +: 32] = vecs[k].data;
            @(negedge clk);
            chk("vec_idle_ready", 64'(pe_up_ready), 64'(0));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("vec_grant_ready", 64'(pe_up_ready), 64'(1) << vecs[k].pe);
            @(posedge clk);
            #1;
            pe_up_valid = '0;
            pe_up_cntl  = '0;
            pe_up_data  = '0;
            @(negedge clk);
            chk("vec_out_valid", 64'(mgr_up_valid), 64'(1));
            chk("vec_out_id", 64'(mgr_up_pe_id), 64'(vecs[k].pe));
            chk("vec_out_cntl", 64'(mgr_up_cntl), 64'(vecs[k].cntl));
            chk("vec_out_data", 64'(mgr_up_data), 64'(vecs[k].data));
            chk("vec_proto_err", 64'(proto_err), 64'(vecs[k].exp_err));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("vec_drained", 64'(mgr_up_valid), 64'(0));
            @(posedge clk);
            #1;
        end

        // Four PEs with 3-beat packets, PE0 with a second one: strict RR order.
        do_reset();
        for (int p = 0; p < NUM_PE; p++) begin
            pe_q[p].push_back(mk(p, 2'b00, {8'(p), 8'd0, 16'd0}));
            pe_q[p].push_back(mk(p, 2'b01, {8'(p), 8'd0, 16'd1}));
            pe_q[p].push_back(mk(p, 2'b10, {8'(p), 8'd0, 16'd2}));
        end
        pe_q[0].push_back(mk(0, 2'b00, {8'd0, 8'd1, 16'd0}));
        pe_q[0].push_back(mk(0, 2'b01, {8'd0, 8'd1, 16'd1}));
        pe_q[0].push_back(mk(0, 2'b10, {8'd0, 8'd1, 16'd2}));
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(mk(n % 4, 2'b00, {8'(n % 4), 8'(n / 4), 16'd0}));
            exp_q.push_back(mk(n % 4, 2'b01, {8'(n % 4), 8'(n / 4), 16'd1}));
            exp_q.push_back(mk(n % 4, 2'b10, {8'(n % 4), 8'(n / 4), 16'd2}));
        end
        drive_pe();
        run_drain(200, "rr_order");
        chk("rr_proto_err", 64'(proto_err), 64'(0));

        // Back-pressure: 10-beat packet into an 8-deep FIFO.
        mgr_up_ready = 1'b0;
        for (int b = 0; b < 10; b++) begin
            sb_t beat;
            beat = mk(1, (b == 0) ? 2'b00 : ((b == 9) ? 2'b10 : 2'b01), 32'h1000 + 32'(b));
            pe_q[1].push_back(beat);
            exp_q.push_back(beat);
        end
        drive_pe();
        repeat (16) tick();
        chk("full_pe1_ready", 64'(pe_up_ready), 64'(0));
        chk("full_left_at_pe1", 64'(pe_q[1].size()), 64'(2));
        chk("full_mgr_valid", 64'(mgr_up_valid), 64'(1));
        mgr_up_ready = 1'b1;
        run_drain(100, "full_drain");

        // Protocol error: first beat MOP, still forwarded, sticky.
        chk("perr_before", 64'(proto_err), 64'(0));
        pe_q[2].push_back(mk(2, 2'b01, 32'h2222_0001));
        pe_q[2].push_back(mk(2, 2'b10, 32'h2222_0002));
        exp_q.push_back(mk(2, 2'b01, 32'h2222_0001));
        exp_q.push_back(mk(2, 2'b10, 32'h2222_0002));
        drive_pe();
        run_drain(50, "perr_mop");
        chk("perr_set", 64'(proto_err), 64'(1));
        pe_q[0].push_back(mk(0, 2'b11, 32'h0000_0077));
        exp_q.push_back(mk(0, 2'b11, 32'h0000_0077));
        drive_pe();
        run_drain(50, "perr_sticky_pkt");
        chk("perr_sticky", 64'(proto_err), 64'(1));
        do_reset();
        chk("perr_cleared", 64'(proto_err), 64'(0));
        // SOP arriving mid-packet is also an error.
        pe_q[3].push_back(mk(3, 2'b00, 32'h3));
        pe_q[3].push_back(mk(3, 2'b00, 32'h4));
        pe_q[3].push_back(mk(3, 2'b10, 32'h5));
        exp_q.push_back(mk(3, 2'b00, 32'h3));
        exp_q.push_back(mk(3, 2'b00, 32'h4));
        exp_q.push_back(mk(3, 2'b10, 32'h5));
        drive_pe();
        run_drain(50, "perr_sop_mid");
        chk("perr_sop_mid", 64'(proto_err), 64'(1));

        // Reset mid-packet with 5 entries queued.
        do_reset();
        mgr_up_ready = 1'b0;
        pe_q[1].push_back(mk(1, 2'b00, 32'h50));
        for (int b = 1; b < 10; b++) pe_q[1].push_back(mk(1, 2'b01, 32'h50 + 32'(b)));
        drive_pe();
        repeat (6) tick();
        chk("mid_rst_pre_valid", 64'(mgr_up_valid), 64'(1));
        chk("mid_rst_accepted", 64'(pe_q[1].size()), 64'(5));
        #2;
        reset_poweron = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(mgr_up_valid), 64'(0));
        chk("mid_rst_ready", 64'(pe_up_ready), 64'(0));
        clear_queues();
        drive_pe();
        @(negedge clk);
        reset_poweron = 1'b0;
        mgr_up_ready  = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < NUM_PE; p++) begin
            pe_q[p].push_back(mk(p, 2'b11, 32'h600 + 32'(p)));
            exp_q.push_back(mk(p, 2'b11, 32'h600 + 32'(p)));
        end
        drive_pe();
        run_drain(50, "post_rst_rr");

`ifdef STACK_BUS_UP_PARITY_EN
        // Parity over {pe_id, cntl, data}.
        do_reset();
        mgr_up_ready = 1'b0;
        pe_q[1].push_back(mk(1, 2'b00, 32'h1));
        pe_q[1].push_back(mk(1, 2'b00, 32'h3));
        pe_q[1].push_back(mk(1, 2'b10, 32'h0));
        exp_q.push_back(mk(1, 2'b00, 32'h1));
        exp_q.push_back(mk(1, 2'b00, 32'h3));
        exp_q.push_back(mk(1, 2'b10, 32'h0));
        drive_pe();
        repeat (6) tick();
        chk("parity_data1", 64'(mgr_up_parity), 64'(0));
        mgr_up_ready = 1'b1;
        tick();
        mgr_up_ready = 1'b0;
        @(negedge clk);
        chk("parity_data3", 64'(mgr_up_parity), 64'(1));
        mgr_up_ready = 1'b1;
        run_drain(50, "parity_drain");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
